// File: rtl/isqrt_arb_pkg.sv
// Shared widths and helpers for the isqrt sharing arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional feature macro: ISQRT_ARB_FIXED_PRIO_EN (used by isqrt_share_arb).
package isqrt_arb_pkg;

  // Operand and root widths of the shared isqrt unit.
  localparam int ARG_W = 32;
  localparam int RES_W = 16;

  // Requester index width; at least one bit so a tag always has an idx field.
  // The tag_t struct {vld, idx[IDX_W-1:0]} is declared where N_REQ is known
  // (isqrt_arb_tag_pipe), because its width follows that parameter.
  function automatic int idx_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/isqrt_arb_tag_pipe.sv
// Tag shift register carrying {vld, requester idx} alongside the isqrt pipeline.
// Latency: DEPTH cycles from in_* to out_*.
// Backpressure: none; shifts every cycle, idx field only moves with a valid tag.
module isqrt_arb_tag_pipe #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  tag_t [DEPTH-1:0] stage;

  // Valid bits shift every cycle; idx is only clocked where a valid tag arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage[0].vld <= in_vld;
      if (in_vld) begin
        stage[0].idx <= in_idx;
      end
      for (int k = 1; k < DEPTH; k++) begin
        stage[k].vld <= stage[k-1].vld;
        if (stage[k-1].vld) begin
          stage[k].idx <= stage[k-1].idx;
        end
      end
    end
  end

  assign out_vld = stage[DEPTH-1].vld;
  assign out_idx = stage[DEPTH-1].idx;

endmodule

// File: rtl/isqrt_share_arb.sv
// Shares one pipelined isqrt among N_REQ requesters and routes each root back to its issuer.
// Latency: request accepted in cycle T -> resp_vld registered at edge T+ISQRT_LATENCY+1.
// Backpressure: one grant per cycle (round-robin, or fixed priority with ISQRT_ARB_FIXED_PRIO_EN); no stall on return.
module isqrt_share_arb
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ         = 3,
  parameter int ISQRT_LATENCY = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*ARG_W-1:0] req_x,
  output logic [N_REQ-1:0]       req_rdy,
  output logic [N_REQ-1:0]       resp_vld,
  output logic [N_REQ*RES_W-1:0] resp_y,
  output logic                   isq_x_vld,
  output logic [ARG_W-1:0]       isq_x,
  input  logic                   isq_y_vld,
  input  logic [RES_W-1:0]       isq_y,
  output logic                   tag_err
);

  localparam int IDX_W = idx_width(N_REQ);

  logic [IDX_W-1:0] ptr;
  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_vec;
  logic [ARG_W-1:0] gnt_x;
  logic [ARG_W-1:0] isq_x_last;
  logic             tag_last_vld;
  logic [IDX_W-1:0] tag_last_idx;

  // First requesting index at or above ptr, wrapping; at most one grant.
  always_comb begin
    int cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_vec = '0;
    cand    = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!gnt_any && req_vld[cand]) begin
        gnt_any       = 1'b1;
        gnt_idx       = IDX_W'(cand);
        gnt_vec[cand] = 1'b1;
      end
    end
  end

  assign req_rdy = gnt_vec;

`ifdef ISQRT_ARB_FIXED_PRIO_EN
  // Fixed priority: search always starts at requester 0.
  assign ptr = '0;
`else
  logic [IDX_W-1:0] ptr_nxt;

  // Next search start is the requester just after the one granted.
  always_comb begin
    ptr_nxt = gnt_idx + IDX_W'(1);
    if (gnt_idx == IDX_W'(N_REQ - 1)) begin
      ptr_nxt = '0;
    end
  end

  // Pointer only advances on a grant so an idle cycle keeps the rotation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= ptr_nxt;
    end
  end
`endif

  // Operand of the granted requester.
  always_comb begin
    gnt_x = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_vec[i]) begin
        gnt_x = req_x[i*ARG_W +: ARG_W];
      end
    end
  end

  // Remember the last issued operand so isq_x does not toggle while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isq_x_last <= '0;
    end else if (gnt_any) begin
      isq_x_last <= gnt_x;
    end
  end

  assign isq_x_vld = gnt_any;
  assign isq_x     = gnt_any ? gnt_x : isq_x_last;

  isqrt_arb_tag_pipe #(
    .DEPTH (ISQRT_LATENCY),
    .IDX_W (IDX_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (gnt_any),
    .in_idx  (gnt_idx),
    .out_vld (tag_last_vld),
    .out_idx (tag_last_idx)
  );

  // Route the returning root to the tagged requester; a vld disagreement is sticky and suppresses the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_vld <= '0;
      resp_y   <= '0;
      tag_err  <= 1'b0;
    end else begin
      resp_vld <= '0;
      if (tag_last_vld != isq_y_vld) begin
        tag_err <= 1'b1;
      end else if (tag_last_vld) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (tag_last_idx == IDX_W'(i)) begin
            resp_vld[i]                <= 1'b1;
            resp_y[i*RES_W +: RES_W]   <= isq_y;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_isqrt_share_arb.sv
// Directed bench for isqrt_share_arb with a behavioural 16-cycle isqrt model.
// Latency under test: request cycle -> resp_vld after the 17th rising edge.
// Backpressure under test: one-hot grants, rotation or fixed priority (ISQRT_ARB_FIXED_PRIO_EN).
`timescale 1ns/1ps
module tb_isqrt_share_arb;

  localparam int N_REQ = 3;
  localparam int LAT   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req_vld = '0;
  logic [95:0] req_x = '0;
  logic [2:0]  req_rdy;
  logic [2:0]  resp_vld;
  logic [47:0] resp_y;
  logic        isq_x_vld;
  logic [31:0] isq_x;
  logic        isq_y_vld;
  logic [15:0] isq_y;
  logic        tag_err;
  logic        inj = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  isqrt_share_arb #(.N_REQ(N_REQ), .ISQRT_LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_x     (req_x),
    .req_rdy   (req_rdy),
    .resp_vld  (resp_vld),
    .resp_y    (resp_y),
    .isq_x_vld (isq_x_vld),
    .isq_x     (isq_x),
    .isq_y_vld (isq_y_vld),
    .isq_y     (isq_y),
    .tag_err   (tag_err)
  );

  function automatic logic [15:0] isqrt32(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    logic [31:0] sq;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t  = r | (16'h1 << b);
      sq = {16'h0, t} * {16'h0, t};
      if (sq <= x) r = t;
    end
    return r;
  endfunction

  // Behavioural isqrt: LAT register stages, shares rst with the arbiter.
  logic [LAT-1:0] mv;
  logic [15:0]    my [LAT];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv <= '0;
      for (int k = 0; k < LAT; k++) my[k] <= '0;
    end else begin
      mv    <= {mv[LAT-2:0], isq_x_vld};
      my[0] <= isqrt32(isq_x);
      for (int k = 1; k < LAT; k++) my[k] <= my[k-1];
    end
  end
  assign isq_y_vld = mv[LAT-1] | inj;
  assign isq_y     = my[LAT-1];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_vld = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_vld = '0;
    rst = 1'b1;
    step();
    n_chk++; if (req_rdy !== 3'b000) begin n_fail++; $display("FAIL reset_req_rdy: got %b want 000", req_rdy); end
    n_chk++; if (resp_vld !== 3'b000) begin n_fail++; $display("FAIL reset_resp_vld: got %b want 000", resp_vld); end
    n_chk++; if (resp_y !== 48'h0) begin n_fail++; $display("FAIL reset_resp_y: got %h want 0", resp_y); end
    n_chk++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL reset_tag_err: got %b want 0", tag_err); end
    n_chk++; if (isq_x_vld !== 1'b0) begin n_fail++; $display("FAIL reset_isq_x_vld: got %b want 0", isq_x_vld); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    req_x = '0;
    req_x[31:0] = 32'd144;
    req_vld = 3'b001;
    #1;
    n_chk++; if (req_rdy !== 3'b001) begin n_fail++; $display("FAIL single_rdy: got %b want 001", req_rdy); end
    n_chk++; if (isq_x_vld !== 1'b1) begin n_fail++; $display("FAIL single_isq_x_vld: got %b want 1", isq_x_vld); end
    n_chk++; if (isq_x !== 32'd144) begin n_fail++; $display("FAIL single_isq_x: got %0d want 144", isq_x); end
    step();
    req_vld = 3'b000;
    for (int n = 1; n <= 20; n++) begin
      logic [2:0] exp_v;
      exp_v = (n == 17) ? 3'b001 : 3'b000;
      n_chk++; if (resp_vld !== exp_v) begin n_fail++; $display("FAIL single_resp_vld step %0d: got %b want %b", n, resp_vld, exp_v); end
      if (n == 17) begin
        n_chk++; if (resp_y[15:0] !== 16'd12) begin n_fail++; $display("FAIL single_resp_y: got %0d want 12", resp_y[15:0]); end
      end
      step();
    end
  endtask

  task automatic test_rotate();
    logic [15:0] y_tab [3];
    y_tab[0] = 16'd0;
    y_tab[1] = 16'd1;
    y_tab[2] = 16'd65535;
    req_x = {32'hFFFF_FFFF, 32'd1, 32'd0};
    for (int i = 0; i < 30; i++) begin
      logic [2:0] exp_rdy;
      logic [2:0] exp_v;
      int s;
      int r;
      req_vld = (i < 9) ? 3'b111 : 3'b000;
      #1;
      if (i < 9) begin
`ifdef ISQRT_ARB_FIXED_PRIO_EN
        exp_rdy = 3'b001;
`else
        exp_rdy = 3'b001 << (i % 3);
`endif
        n_chk++; if (req_rdy !== exp_rdy) begin n_fail++; $display("FAIL rotate_rdy cycle %0d: got %b want %b", i, req_rdy, exp_rdy); end
      end
      step();
      s = i + 1;
      exp_v = 3'b000;
      r = 0;
      if (s >= 17 && s <= 25) begin
`ifdef ISQRT_ARB_FIXED_PRIO_EN
        r = 0;
`else
        r = (s - 17) % 3;
`endif
        exp_v = 3'b001 << r;
      end
      n_chk++; if (resp_vld !== exp_v) begin n_fail++; $display("FAIL rotate_resp_vld step %0d: got %b want %b", s, resp_vld, exp_v); end
      if (exp_v != 3'b000) begin
        n_chk++; if (resp_y[r*16 +: 16] !== y_tab[r]) begin n_fail++; $display("FAIL rotate_resp_y step %0d: got %0d want %0d", s, resp_y[r*16 +: 16], y_tab[r]); end
      end
    end
  endtask

  task automatic test_idle();
    logic [31:0] exp_hold;
`ifdef ISQRT_ARB_FIXED_PRIO_EN
    exp_hold = 32'd0;
`else
    exp_hold = 32'hFFFF_FFFF;
`endif
    req_vld = 3'b000;
    for (int n = 0; n < 20; n++) begin
      step();
      n_chk++; if (isq_x_vld !== 1'b0) begin n_fail++; $display("FAIL idle_isq_x_vld: got %b want 0", isq_x_vld); end
      n_chk++; if (isq_x !== exp_hold) begin n_fail++; $display("FAIL idle_isq_x: got %h want %h", isq_x, exp_hold); end
      n_chk++; if (resp_vld !== 3'b000) begin n_fail++; $display("FAIL idle_resp_vld: got %b want 000", resp_vld); end
    end
  endtask

  typedef struct {
    int          r;
    logic [15:0] y;
  } exp_t;

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    logic [15:0] rt [3];
    logic [31:0] sq;
    for (int c = 0; c < 1020; c++) begin
      if (c < 1000) begin
        req_vld = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b010;
        for (int i = 0; i < 3; i++) begin
          rt[i] = 16'($urandom_range(0, 65535));
          sq = {16'h0, rt[i]} * {16'h0, rt[i]};
          req_x[i*32 +: 32] = sq;
        end
      end else begin
        req_vld = 3'b000;
      end
      #1;
      n_chk++;
      if (($countones(req_rdy) > 1) || ((req_rdy & ~req_vld) != 3'b000) ||
          ((req_vld != 3'b000) && (req_rdy == 3'b000))) begin
        n_fail++; $display("FAIL random_grant cycle %0d: rdy %b vld %b", c, req_rdy, req_vld);
      end
      for (int i = 0; i < 3; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          e.r = i;
          e.y = rt[i];
          q.push_back(e);
        end
      end
      step();
      if (resp_vld != 3'b000) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL random_unexpected_resp cycle %0d: got %b want 000", c, resp_vld);
        end else begin
          logic [2:0] exp_v;
          e = q.pop_front();
          exp_v = 3'b001 << e.r;
          if (resp_vld !== exp_v || resp_y[e.r*16 +: 16] !== e.y) begin
            n_fail++; $display("FAIL random_resp cycle %0d: got vld %b y %0d want vld %b y %0d", c, resp_vld, resp_y[e.r*16 +: 16], exp_v, e.y);
          end
        end
      end
    end
    n_chk++; if (q.size() != 0) begin n_fail++; $display("FAIL random_drain: got %0d outstanding want 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    req_x = {32'd900, 32'd400, 32'd100};
    req_vld = 3'b111;
    for (int n = 0; n < 5; n++) step();
    req_vld = 3'b000;
    rst = 1'b1;
    #1;
    n_chk++; if (resp_vld !== 3'b000) begin n_fail++; $display("FAIL rstmid_resp_vld: got %b want 000", resp_vld); end
    n_chk++; if (resp_y !== 48'h0) begin n_fail++; $display("FAIL rstmid_resp_y: got %h want 0", resp_y); end
    n_chk++; if (req_rdy !== 3'b000) begin n_fail++; $display("FAIL rstmid_req_rdy: got %b want 000", req_rdy); end
    n_chk++; if (isq_x_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_isq_x_vld: got %b want 0", isq_x_vld); end
    n_chk++; if (isq_x !== 32'h0) begin n_fail++; $display("FAIL rstmid_isq_x: got %h want 0", isq_x); end
    n_chk++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_tag_err: got %b want 0", tag_err); end
    step();
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      n_chk++; if (resp_vld !== 3'b000 || tag_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale step %0d: got vld %b err %b want 000 0", n, resp_vld, tag_err); end
    end
  endtask

  task automatic test_tag_err();
    req_vld = 3'b000;
    step();
    n_chk++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL tagerr_before: got %b want 0", tag_err); end
    inj = 1'b1;
    step();
    inj = 1'b0;
    n_chk++; if (tag_err !== 1'b1) begin n_fail++; $display("FAIL tagerr_set: got %b want 1", tag_err); end
    n_chk++; if (resp_vld !== 3'b000) begin n_fail++; $display("FAIL tagerr_resp_vld: got %b want 000", resp_vld); end
    for (int n = 0; n < 5; n++) step();
    n_chk++; if (tag_err !== 1'b1) begin n_fail++; $display("FAIL tagerr_sticky: got %b want 1", tag_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    do_reset();
    test_rotate();
    test_idle();
    do_reset();
    test_random();
    test_reset_mid();
    test_tag_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
